// File: rtl/ctrl_display_bcd_if.sv
// ctrl_display_bcd_if
// Connects the BCD peripheral to the display scan controller.
// Signals:
//   en_i     1 = scan the display, 0 = display off
//   we_i     write strobe, captures bcd_i
//   bcd_i    packed BCD word, nibble k = digit k (k=0 is the LSD)
//   anodo_o  digit enables, active-low
//   seg_o    segments {g,f,e,d,c,b,a}, active-low
//   dp_o     decimal point, active-low (always off)
//   frame_o  one-cycle pulse when digit 0 is lit at frame start
// master drives the controls, slave is the scan controller.
interface ctrl_display_bcd_if #(
    parameter int N_DIGITS = 8
);
    logic                    en_i;
    logic                    we_i;
    logic [4*N_DIGITS-1:0]   bcd_i;
    logic [N_DIGITS-1:0]     anodo_o;
    logic [6:0]              seg_o;
    logic                    dp_o;
    logic                    frame_o;

    modport master (
        output en_i, we_i, bcd_i,
        input  anodo_o, seg_o, dp_o, frame_o
    );

    modport slave (
        input  en_i, we_i, bcd_i,
        output anodo_o, seg_o, dp_o, frame_o
    );
endinterface

// File: rtl/ctrl_display_bcd.sv
// ctrl_display_bcd
// Scan controller for a multiplexed 7-segment display. A pending copy of
// the BCD word is taken on every write; it moves into the displayed copy
// only when a new frame starts, so a frame never shows a mix of two words.
// Each digit is lit for REFRESH_DIV cycles, followed by BLANK_CYC cycles
// with all anodes off, and leading zeros can be blanked.
// Ports:
//   clk_i   system clock, rising edge
//   rst_i   asynchronous reset, active-low
//   bus     ctrl_display_bcd_if.slave (en/we/bcd in, anodes/segs/dp/frame out)
//
// state | meaning
// IDLE  | display off, all anodes high, counters cleared
// SCAN  | digit idx lit for REFRESH_DIV cycles
// GAP   | all anodes off for BLANK_CYC cycles before the next digit
module ctrl_display_bcd #(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 10000,
    parameter int BLANK_CYC   = 100,
    parameter int BLANK_LZ    = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    ctrl_display_bcd_if.slave  bus
);
    localparam int W    = 4 * N_DIGITS;
    localparam int IW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int MAXC = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] SCAN_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = (BLANK_CYC > 0) ? CW'(BLANK_CYC - 1) : '0;
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, GAP} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [W-1:0]          pend_q, pend_d;
    logic                  pend_v_q, pend_v_d;
    logic [W-1:0]          disp_q, disp_d;
    logic [N_DIGITS-1:0]   anodo_q, anodo_d;
    logic [6:0]            seg_q, seg_d;
    logic                  frame_q, frame_d;
    logic                  load;
    logic                  lz_blank;
    logic [3:0]            nib;
    logic [IW-1:0]         idx_nxt;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CW'(1);
        load    = 1'b0;
        idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

        if (!bus.en_i) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SCAN;
                    idx_d   = '0;
                    cnt_d   = '0;
                    load    = 1'b1;
                end
                SCAN: begin
                    if (cnt_q == SCAN_LAST) begin
                        cnt_d = '0;
                        if (BLANK_CYC > 0) begin
                            state_d = GAP;
                        end else begin
                            idx_d = idx_nxt;
                            load  = (idx_q == IDX_LAST);
                        end
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = '0;
                        state_d = SCAN;
                        idx_d   = idx_nxt;
                        load    = (idx_q == IDX_LAST);
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // The frame load reads the old pending word, so a write on the same
    // edge stays pending and is shown one frame later.
    always_comb begin
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        disp_d   = disp_q;
        if (load && pend_v_q) begin
            disp_d   = pend_q;
            pend_v_d = 1'b0;
        end
        if (bus.we_i) begin
            pend_d   = bus.bcd_i;
            pend_v_d = 1'b1;
        end
    end

    // Outputs are computed from the next state so the registered outputs
    // line up with the state they describe.
    always_comb begin
        anodo_d  = '1;
        seg_d    = 7'h7F;
        frame_d  = load;
        nib      = disp_d[{idx_d, 2'b00} +: 4];
        lz_blank = (BLANK_LZ != 0) && (idx_d != '0);
        for (int j = 0; j < N_DIGITS; j++) begin
            if (j >= int'(idx_d) && disp_d[4*j +: 4] != 4'd0) begin
                lz_blank = 1'b0;
            end
        end
        if (state_d == SCAN) begin
            anodo_d[idx_d] = 1'b0;
            seg_d          = lz_blank ? 7'h7F : decode(nib);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            disp_q   <= '0;
            anodo_q  <= '1;
            seg_q    <= 7'h7F;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            disp_q   <= disp_d;
            anodo_q  <= anodo_d;
            seg_q    <= seg_d;
            frame_q  <= frame_d;
        end
    end

    assign bus.anodo_o = anodo_q;
    assign bus.seg_o   = seg_q;
    assign bus.dp_o    = 1'b1;
    assign bus.frame_o = frame_q;
endmodule

// File: tb/tb_ctrl_display_bcd.sv
// tb_ctrl_display_bcd
// Directed bench for ctrl_display_bcd with REFRESH_DIV=4, BLANK_CYC=1
// (40-cycle frame). Two instances run in lockstep on the same inputs:
// one with leading-zero blanking, one without.
module tb_ctrl_display_bcd;
    localparam int ND    = 8;
    localparam int RD    = 4;
    localparam int BC    = 1;
    localparam int FRAME = ND * (RD + BC);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        we = 1'b0;
    logic [31:0] bcd = '0;

    int n_chk = 0;
    int n_bad = 0;

    ctrl_display_bcd_if #(.N_DIGITS(ND)) bus_lz ();
    ctrl_display_bcd_if #(.N_DIGITS(ND)) bus_all ();

    assign bus_lz.en_i   = en;
    assign bus_lz.we_i   = we;
    assign bus_lz.bcd_i  = bcd;
    assign bus_all.en_i  = en;
    assign bus_all.we_i  = we;
    assign bus_all.bcd_i = bcd;

    ctrl_display_bcd #(.N_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYC(BC), .BLANK_LZ(1)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_lz.slave)
    );

    ctrl_display_bcd #(.N_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYC(BC), .BLANK_LZ(0)) dut_nolz (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_all.slave)
    );

    always #5 clk = ~clk;

    // Expected segment patterns, digit 7 first ... digit 0 last.
    localparam logic [55:0] A_LZ  = {7'h7F, 7'h7F, 7'h30, 7'h19, 7'h12, 7'h24, 7'h30, 7'h79};
    localparam logic [55:0] A_ALL = {7'h40, 7'h40, 7'h30, 7'h19, 7'h12, 7'h24, 7'h30, 7'h79};
    localparam logic [55:0] B_LZ  = {7'h7F, 7'h7F, 7'h79, 7'h30, 7'h19, 7'h24, 7'h79, 7'h19};
    localparam logic [55:0] B_ALL = {7'h40, 7'h40, 7'h79, 7'h30, 7'h19, 7'h24, 7'h79, 7'h19};
    localparam logic [55:0] C_LZ  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F};
    localparam logic [55:0] C_ALL = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h3F};
    localparam logic [55:0] N_ALL = {7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10};

    localparam logic [31:0] WORD_A = 32'h00345231;
    localparam logic [31:0] WORD_B = 32'h00134214;
    localparam logic [31:0] WORD_C = 32'h0000000A;
    localparam logic [31:0] WORD_N = 32'h99999999;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Write one word: strobe for one edge, leave we low afterwards.
    task automatic do_write(input logic [31:0] w);
        we  = 1'b1;
        bcd = w;
        @(negedge clk);
        we  = 1'b0;
    endtask

    // Bounded wait until frame_o is seen high at a falling edge.
    task automatic wait_frame(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 3 * FRAME && !got; i++) begin
            @(negedge clk);
            if (bus_lz.frame_o) got = 1'b1;
        end
        chk(tag, 32'(got), 32'd1);
    endtask

    // Called at the falling edge where frame_o is high. Checks one whole
    // frame, optionally issuing writes at frame cycles wa1/wa2, and ends at
    // the falling edge that starts the next frame.
    task automatic check_frame(input string name,
                               input logic [55:0] e_lz, input logic [55:0] e_all,
                               input int wa1, input logic [31:0] w1,
                               input int wa2, input logic [31:0] w2);
        for (int c = 0; c < FRAME; c++) begin
            int         k;
            int         ph;
            logic [7:0] xan;
            logic [6:0] xl;
            logic [6:0] xa;
            k  = c / (RD + BC);
            ph = c % (RD + BC);
            if (c > 0) @(negedge clk);
            if (ph < RD) begin
                xan = ~(8'h01 << k);
                xl  = e_lz[7*k +: 7];
                xa  = e_all[7*k +: 7];
            end else begin
                xan = 8'hFF;
                xl  = 7'h7F;
                xa  = 7'h7F;
            end
            chk($sformatf("%s anode c%0d", name, c), 32'(bus_lz.anodo_o), 32'(xan));
            chk($sformatf("%s seg_lz c%0d", name, c), 32'(bus_lz.seg_o), 32'(xl));
            chk($sformatf("%s seg_all c%0d", name, c), 32'(bus_all.seg_o), 32'(xa));
            chk($sformatf("%s frame c%0d", name, c), 32'(bus_lz.frame_o), (c == 0) ? 32'd1 : 32'd0);
            we = 1'b0;
            if (c == wa1) begin
                we  = 1'b1;
                bcd = w1;
            end
            if (c == wa2) begin
                we  = 1'b1;
                bcd = w2;
            end
        end
        @(negedge clk);
        we = 1'b0;
        chk($sformatf("%s frame_period", name), 32'(bus_lz.frame_o), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst anode", 32'(bus_lz.anodo_o), 32'hFF);
        chk("rst seg", 32'(bus_lz.seg_o), 32'h7F);
        chk("rst dp", 32'(bus_lz.dp_o), 32'd1);
        chk("rst frame", 32'(bus_lz.frame_o), 32'd0);
        chk("rst anode nolz", 32'(bus_all.anodo_o), 32'hFF);

        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle anode", 32'(bus_lz.anodo_o), 32'hFF);
        end

        en = 1'b1;
        wait_frame("first frame");
        chk("zero d0 anode", 32'(bus_lz.anodo_o), 32'hFE);
        chk("zero d0 seg", 32'(bus_lz.seg_o), 32'h40);

        // Asynchronous reset in the middle of digit 0.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst anode", 32'(bus_lz.anodo_o), 32'hFF);
        chk("async rst seg", 32'(bus_lz.seg_o), 32'h7F);
        chk("async rst frame", 32'(bus_lz.frame_o), 32'd0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post rst idle anode", 32'(bus_lz.anodo_o), 32'hFF);
        end

        en = 1'b1;
        do_write(WORD_A);
        wait_frame("frame A");
        check_frame("A0", A_LZ, A_ALL, -1, '0, -1, '0);
        check_frame("A1", A_LZ, A_ALL, 16, WORD_B, -1, '0);
        check_frame("B", B_LZ, B_ALL, -1, '0, -1, '0);

        do_write(WORD_C);
        wait_frame("frame C");
        check_frame("C", C_LZ, C_ALL, -1, '0, -1, '0);

        do_write(WORD_N);
        wait_frame("frame N");
        check_frame("N0", N_ALL, N_ALL, -1, '0, -1, '0);

        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("en off anode", 32'(bus_lz.anodo_o), 32'hFF);
            chk("en off anode nolz", 32'(bus_all.anodo_o), 32'hFF);
            chk("en off frame", 32'(bus_lz.frame_o), 32'd0);
        end
        en = 1'b1;
        @(negedge clk);
        chk("restart frame", 32'(bus_lz.frame_o), 32'd1);
        chk("restart anode", 32'(bus_lz.anodo_o), 32'hFE);

        // A pending write, then another on the frame-load edge.
        check_frame("N1", N_ALL, N_ALL, 10, WORD_A, FRAME - 1, WORD_B);
        check_frame("A2", A_LZ, A_ALL, -1, '0, -1, '0);
        check_frame("B2", B_LZ, B_ALL, -1, '0, -1, '0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
